// File: rtl/mmem_responder_pkg.sv
// rtl/mmem_responder_pkg.sv - shared bus encodings and I/O window decode for mmem_responder
package mmem_responder_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam logic [31:0] IO_STAT_OFFSET  = 32'd4;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_rw_e;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IO_DATA,
        SEL_IO_STAT,
        SEL_NONE
    } mem_sel_e;

    // RAM takes priority: the I/O window must sit above the RAM range for it to be reachable.
    function automatic mem_sel_e decode_addr(input logic [31:0] addr,
                                             input int unsigned ram_bits,
                                             input logic [31:0] io_base);
        if ((addr >> ram_bits) == 32'd0) begin
            return SEL_RAM;
        end else if (addr == io_base) begin
            return SEL_IO_DATA;
        end else if (addr == io_base + IO_STAT_OFFSET) begin
            return SEL_IO_STAT;
        end
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO with combinational head, push accepted on full when popping
module byte_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = !rst && pop && !empty;
        do_push  = !rst && push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, do_pop};
        count_d  = count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mmem_responder.sv
// rtl/mmem_responder.sv - byte-wide main-memory responder with RAM and host-link I/O window
module mmem_responder
    import mmem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 17,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmem_r_w,
    input  logic [31:0] mmem_addr,
    input  logic [7:0]  mmem_data,
    output logic [7:0]  data_get,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        io_full,
    output logic        sim_halt
);

    // Contents are intentionally not reset; simulation preloads them externally.
    logic [7:0] ram [2**ADDR_WIDTH];

    mem_sel_e   sel;
    logic       is_write;
    logic       ram_we;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] rx_head;
    logic [FIFO_DEPTH_LOG2:0] tx_count, rx_count;
    logic [7:0] status;

    logic [7:0] data_get_q, data_get_d;
    logic       halt_q, halt_d;

    assign sel      = decode_addr(mmem_addr, ADDR_WIDTH, IO_BASE);
    assign is_write = (mem_rw_e'(mmem_r_w) == MEM_WRITE);

    assign ram_we  = !rst && is_write && (sel == SEL_RAM);
    assign tx_push = !rst && is_write && (sel == SEL_IO_DATA);
    assign rx_pop  = !rst && !is_write && (sel == SEL_IO_DATA);
    assign rx_push = !rst && rx_valid && rx_ready;
    assign tx_pop  = !rst && tx_valid && tx_ready;

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign io_full  = tx_full;
    assign data_get = data_get_q;
    assign sim_halt = halt_q;

    // The count MSB is set only at DEPTH, so it doubles as the status full bit.
    assign status = {6'b0, tx_count[FIFO_DEPTH_LOG2], |rx_count};

    byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (mmem_data),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    byte_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        data_get_d = 8'h00;
        halt_d     = halt_q;
        if (!is_write) begin
            case (sel)
                SEL_RAM:     data_get_d = ram[mmem_addr[ADDR_WIDTH-1:0]];
                SEL_IO_DATA: data_get_d = rx_empty ? 8'h00 : rx_head;
                SEL_IO_STAT: data_get_d = status;
                default:     data_get_d = 8'h00;
            endcase
        end else if (sel == SEL_IO_STAT) begin
            halt_d = 1'b1;
        end
        if (rst) begin
            data_get_d = 8'h00;
            halt_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        data_get_q <= data_get_d;
        halt_q     <= halt_d;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[mmem_addr[ADDR_WIDTH-1:0]] <= mmem_data;
        end
    end

endmodule

// File: tb/tb_mmem_responder.sv
// tb/tb_mmem_responder.sv - scoreboard bench for mmem_responder
module tb_mmem_responder;

    localparam logic [31:0] IO_BASE   = 32'h0003_0000;
    localparam logic [31:0] IO_STAT   = 32'h0003_0004;
    localparam logic [31:0] IDLE_ADDR = 32'h0004_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmem_r_w;
    logic [31:0] mmem_addr;
    logic [7:0]  mmem_data;
    logic [7:0]  data_get;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        io_full;
    logic        sim_halt;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .mmem_r_w  (mmem_r_w),
        .mmem_addr (mmem_addr),
        .mmem_data (mmem_data),
        .data_get  (data_get),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .io_full   (io_full),
        .sim_halt  (sim_halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus access: drive at negedge, sample data_get at the following negedge.
    task automatic bus(input logic rw, input logic [31:0] addr, input logic [7:0] wdata,
                       input bit chk, input logic [7:0] exp, input string tag);
        sb_entry_t ent;
        mmem_r_w  = rw;
        mmem_addr = addr;
        mmem_data = wdata;
        sb_q.push_back('{chk: chk, exp: exp, tag: tag});
        @(posedge clk);
        @(negedge clk);
        ent = sb_q.pop_front();
        if (ent.chk) check(ent.tag, {24'h0, data_get}, {24'h0, ent.exp});
    endtask

    task automatic idle();
        bus(1'b0, IDLE_ADDR, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [7:0] e;
        rst = 1'b1; mmem_r_w = 1'b0; mmem_addr = IDLE_ADDR; mmem_data = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data_get", {24'h0, data_get}, 32'h0);
        check("rst_sim_halt", {31'h0, sim_halt}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_io_full",  {31'h0, io_full},  32'h0);
        rst = 1'b0;

        // RAM write then back-to-back reads
        bus(1'b1, 32'h10, 8'hA5, 1'b0, 8'h00, "");
        bus(1'b1, 32'h11, 8'h3C, 1'b0, 8'h00, "");
        bus(1'b0, 32'h10, 8'h00, 1'b1, 8'hA5, "ram_rd_10");
        bus(1'b0, 32'h11, 8'h00, 1'b1, 8'h3C, "ram_rd_11");
        // Read-after-write on the very next cycle
        bus(1'b1, 32'h20, 8'h99, 1'b0, 8'h00, "");
        bus(1'b0, 32'h20, 8'h00, 1'b1, 8'h99, "ram_raw");

        // Four-byte stream
        for (int i = 0; i < 4; i++) bus(1'b1, 32'h100 + i, 8'h11 * (i + 1), 1'b0, 8'h00, "");
        for (int i = 0; i < 4; i++) bus(1'b0, 32'h100 + i, 8'h00, 1'b1, 8'h11 * (i + 1), "ram_stream");

        // TX fill past full with the host stalled
        for (int i = 0; i < 9; i++) begin
            if (tx_model.size() < 8) tx_model.push_back(8'h41 + i);
            bus(1'b1, IO_BASE, 8'h41 + i, 1'b0, 8'h00, "");
            check("tx_io_full", {31'h0, io_full}, {31'h0, tx_model.size() == 8});
        end
        bus(1'b0, IO_STAT, 8'h00, 1'b1, 8'h02, "stat_tx_full");
        tx_ready = 1'b1;
        guard = 0;
        while (tx_model.size() > 0 && guard < 20) begin
            check("tx_valid", {31'h0, tx_valid}, 32'h1);
            check("tx_data", {24'h0, tx_data}, {24'h0, tx_model[0]});
            idle();
            void'(tx_model.pop_front());
            guard++;
        end
        check("tx_drain_bound", tx_model.size(), 32'h0);
        check("tx_empty_after", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // RX single byte
        rx_valid = 1'b1; rx_data = 8'h7E;
        idle();
        rx_valid = 1'b0;
        bus(1'b0, IO_STAT, 8'h00, 1'b1, 8'h01, "stat_rx");
        bus(1'b0, IO_BASE, 8'h00, 1'b1, 8'h7E, "rx_pop");
        bus(1'b0, IO_BASE, 8'h00, 1'b1, 8'h00, "rx_pop_empty");
        bus(1'b0, IO_STAT, 8'h00, 1'b1, 8'h00, "stat_empty");

        // RX fill past full, then drain through the bus
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'hC0 + i;
            check("rx_ready", {31'h0, rx_ready}, {31'h0, rx_model.size() < 8});
            if (rx_model.size() < 8) rx_model.push_back(8'hC0 + i);
            idle();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            e = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
            bus(1'b0, IO_BASE, 8'h00, 1'b1, e, "rx_drain");
        end

        // Halt and out-of-range
        bus(1'b1, 32'h0, 8'h5A, 1'b0, 8'h00, "");
        bus(1'b1, IO_STAT, 8'h00, 1'b0, 8'h00, "");
        check("halt_set", {31'h0, sim_halt}, 32'h1);
        bus(1'b0, IDLE_ADDR, 8'h00, 1'b1, 8'h00, "oor_read");
        bus(1'b1, IDLE_ADDR, 8'hFF, 1'b0, 8'h00, "");
        bus(1'b0, 32'h0, 8'h00, 1'b1, 8'h5A, "oor_no_alias");
        check("halt_sticky", {31'h0, sim_halt}, 32'h1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) bus(1'b1, IO_BASE, 8'h60 + i, 1'b0, 8'h00, "");
        rx_valid = 1'b1; rx_data = 8'h33;
        idle(); idle();
        rx_valid = 1'b0;
        bus(1'b0, 32'h10, 8'h00, 1'b1, 8'hA5, "pre_rst_rd");
        rst = 1'b1; mmem_r_w = 1'b1; mmem_addr = 32'h10; mmem_data = 8'h00;
        rx_valid = 1'b1; rx_data = 8'h44; tx_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("mid_rst_sim_halt", {31'h0, sim_halt}, 32'h0);
        check("mid_rst_data_get", {24'h0, data_get}, 32'h0);
        check("mid_rst_io_full",  {31'h0, io_full},  32'h0);
        rst = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        bus(1'b0, 32'h10, 8'h00, 1'b1, 8'hA5, "ram_kept");
        bus(1'b0, IO_BASE, 8'h00, 1'b1, 8'h00, "rx_flushed");
        bus(1'b0, IO_STAT, 8'h00, 1'b1, 8'h00, "stat_flushed");
        check("tx_flushed", {31'h0, tx_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmem_responder.md
Name: mmem_responder

Overview:
- Byte-wide main-memory responder on the far side of the memory-controller bus (mmem_r_w / mmem_addr / mmem_data / data_get).
- Serves one byte per cycle from an on-chip RAM and decodes a small I/O window for the host link.
- I/O window: a TX byte FIFO toward the host, an RX byte FIFO from the host, a status register, and a halt register.
- Sits at the top level between the memory controller and the host/UART shell.

Parameters:
- ADDR_WIDTH, 17: RAM byte-address bits; RAM depth = 2^ADDR_WIDTH bytes.
- FIFO_DEPTH_LOG2, 3: log2 of TX and RX FIFO depth (8 entries each).
- IO_BASE, 32'h0003_0000: base address of the I/O window.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mmem_r_w  in  1  0 = read, 1 = write; sampled every cycle.
- mmem_addr  in  32  byte address.
- mmem_data  in  8  write byte.
- data_get  out  8  read byte.
- rx_valid  in  1  host byte available.
- rx_data  in  8  host byte.
- rx_ready  out  1  RX FIFO not full.
- tx_valid  out  1  TX FIFO not empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  host accepts head byte.
- io_full  out  1  TX FIFO full; the memory controller must not issue a TX write.
- sim_halt  out  1  sticky halt flag.

Behaviour:
- Access every cycle, no handshake. Each posedge with rst=0 performs exactly one access decoded from mmem_addr and mmem_r_w.

Read latency:
- data_get is registered.
- Value for the address sampled at edge n appears after edge n and stays stable until edge n+1.
- Back-to-back consecutive addresses stream one byte per cycle.

Address decode:
- addr[31:ADDR_WIDTH]==0 -> RAM at addr[ADDR_WIDTH-1:0].
- addr==IO_BASE -> TX/RX data register.
- addr==IO_BASE+4 -> status/halt register.
- Any other address:
  - read returns 8'h00;
  - write is ignored.

RAM:
- Write stores mmem_data at the addressed byte.
- Read returns the stored byte.
- Read-after-write to the same address on the next cycle returns the new byte.
- RAM contents are not cleared by reset; initial contents are loaded by $readmemh in simulation.

IO_BASE write:
- Push mmem_data into the TX FIFO.
- If the TX FIFO is full the byte is dropped and the FIFO is unchanged.

IO_BASE read:
- Pop the RX FIFO; data_get = popped byte.
- If the RX FIFO is empty, data_get = 8'h00 and nothing pops.

IO_BASE+4 read:
- data_get = {6'b0, tx_full, rx_nonempty}.

IO_BASE+4 write:
- sim_halt <= 1 regardless of data.
- Sticky until reset.

Host side:
- RX push when rx_valid && rx_ready.
- TX pop when tx_valid && tx_ready.
- tx_data is the current head, shown combinationally from the FIFO.

FIFO boundaries:
- Push and pop in the same cycle:
  - when non-empty and non-full, count is unchanged;
  - when empty, push only (a pop of empty is ignored);
  - when full, pop occurs and push is accepted the same cycle (count stays at DEPTH).
- Pointers wrap modulo DEPTH.
- Count width is FIFO_DEPTH_LOG2+1.

Reset (synchronous):
- data_get=0, sim_halt=0.
- Both FIFOs empty: tx_valid=0, rx_ready=1, io_full=0.
- Reset asserted mid-stream discards FIFO contents and any in-flight read byte.
- While rst=1, no RAM writes occur and no FIFO pushes or pops occur.

Decomposition:
- Shared defines: IO_BASE, IO status offset 4, mem_r_w encoding (READ=0, WRITE=1). Put these in defines.v beside the existing bus widths.
- One sub-module: byte_fifo (parameterised depth, push/pop/full/empty/count, synchronous reset), instantiated twice (TX and RX).
- The RAM array stays inline.

Test Plan:
- RAM write/read: write 8'hA5 to 0x10, 8'h3C to 0x11; then read 0x10, 0x11 on consecutive cycles -> data_get = A5 then 3C, each one cycle after its address.
- Four-byte streaming read: preload 0x100..0x103 = 11, 22, 33, 44; issue addresses on four consecutive cycles -> data_get shows 11, 22, 33, 44 on consecutive cycles.
- TX FIFO:
  - hold tx_ready=0 and write 0x41..0x49 (9 bytes) to IO_BASE -> io_full=1 after the 8th; the 9th is dropped.
  - then tx_ready=1 -> tx_data emits 41..48 in order, then tx_valid=0.
- RX FIFO: push 0x7E from the host; read IO_BASE+4 -> 8'h01; read IO_BASE -> 7E; read IO_BASE again -> 00; status -> 00.
- Halt and out-of-range: write IO_BASE+4 -> sim_halt=1 and stays 1; read 0x0004_0000 -> 00; write to it leaves RAM unchanged.
- Reset mid-operation: TX holds 3 bytes and RX holds 2; assert rst for 1 cycle -> tx_valid=0, rx_ready=1, sim_halt=0, data_get=00; RAM byte at 0x10 is still A5.
